// File: rtl/encrypt_config.sv
// Shared types for the encrypt/decrypt arbiter: requester IDs, pipe tags and FSM states.
package encrypt_config;

  localparam int unsigned ARB_N_REQ = 2;
  localparam int unsigned ARB_ID_W  = (ARB_N_REQ > 1) ? $clog2(ARB_N_REQ) : 1;

  typedef logic [ARB_ID_W-1:0] arb_id_t;

  typedef struct packed {
    logic    valid;
    arb_id_t id;
  } arb_tag_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACTIVE,
    ARB_DRAIN
  } arb_state_t;

endpackage

// File: rtl/encrypt_arb_tag_pipe.sv
// PIPE_LAT-deep shift register of requester tags that mirrors the datapath latency.
module encrypt_arb_tag_pipe
  import encrypt_config::*;
#(
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic     clk,
  input  logic     flush,
  input  arb_tag_t tag_in,
  output arb_tag_t tag_out
);

  arb_tag_t [PIPE_LAT-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < PIPE_LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[PIPE_LAT-1];

endmodule

// File: rtl/encrypt_decrypt_arbiter.sv
// Round-robin arbiter sharing one encrypt/decrypt datapath between requesters.
// Define ENCRYPT_ARB_STATS_EN to add per-requester grant and response counters.
module encrypt_decrypt_arbiter
  import encrypt_config::*;
#(
  parameter int unsigned N_REQ    = ARB_N_REQ,  // must match ARB_N_REQ (sets arb_id_t)
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    enable,
  output logic [DATA_W-1:0]       data_in_encrypt,
  input  logic                    decrypt_valid_out,
  input  logic [DATA_W-1:0]       decrypted_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
`ifdef ENCRYPT_ARB_STATS_EN
  output logic [N_REQ*16-1:0]     grant_cnt,
  output logic [15:0]             resp_cnt,
`endif
  output logic                    lat_err
);

  localparam int unsigned CntW  = $clog2(MAX_OUT + 1);
  localparam int unsigned IgnW  = $clog2(PIPE_LAT + 1);
  localparam int unsigned SumW  = $clog2(N_REQ * MAX_OUT + 1);
  localparam int unsigned ScanW = ARB_ID_W + 1;

  typedef logic [ScanW-1:0] scan_t;

  logic [N_REQ-1:0][CntW-1:0] credit_q, credit_d;
  arb_id_t                    rr_q;
  arb_state_t                 state_q;
  logic [N_REQ-1:0]           rsp_valid_q;
  logic [DATA_W-1:0]          rsp_data_q;
  logic                       lat_err_q;
  logic [IgnW-1:0]            ign_q;

  logic [N_REQ-1:0] eligible, grant, ret_hit;
  logic             grant_any;
  arb_id_t          grant_id, rr_next;
  scan_t            scan;
  logic [SumW-1:0]  out_sum;
  arb_tag_t         tag_in, tag_out;
  logic             missing, spurious;

  // Grant: first eligible requester scanning upward from the rr pointer.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = !rst && req_valid[i] && (credit_q[i] < CntW'(MAX_OUT));
    end
    grant_any = 1'b0;
    grant_id  = '0;
    scan      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, rr_q} + scan_t'(k);
      if (scan >= scan_t'(N_REQ)) scan = scan - scan_t'(N_REQ);
      if (!grant_any && eligible[scan[ARB_ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = scan[ARB_ID_W-1:0];
      end
    end
    grant = '0;
    if (grant_any) grant[grant_id] = 1'b1;
  end

  always_comb begin
    data_in_encrypt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) data_in_encrypt = data_in_encrypt | req_data[i*DATA_W +: DATA_W];
    end
  end

  assign req_ready = grant;
  assign enable    = grant_any;
  assign rr_next   = (grant_id == arb_id_t'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = grant_any;
    tag_in.id    = grant_id;
  end

  encrypt_arb_tag_pipe #(
    .PIPE_LAT(PIPE_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .flush  (rst),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  // Stale datapath valids right after reset are not errors: the pipe was flushed.
  assign missing  = tag_out.valid && !decrypt_valid_out;
  assign spurious = !tag_out.valid && decrypt_valid_out && (ign_q == '0);

  always_comb begin
    out_sum = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ret_hit[i]  = tag_out.valid && (tag_out.id == arb_id_t'(i));
      credit_d[i] = credit_q[i];
      if (grant[i] && !ret_hit[i] && (credit_q[i] != CntW'(MAX_OUT))) begin
        credit_d[i] = credit_q[i] + 1'b1;
      end else if (ret_hit[i] && !grant[i] && (credit_q[i] != '0)) begin
        credit_d[i] = credit_q[i] - 1'b1;
      end
      out_sum = out_sum + SumW'(credit_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q    <= '0;
      rr_q        <= '0;
      state_q     <= ARB_IDLE;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      lat_err_q   <= 1'b0;
      ign_q       <= IgnW'(PIPE_LAT);
    end else begin
      credit_q    <= credit_d;
      if (grant_any) rr_q <= rr_next;
      rsp_valid_q <= ret_hit & {N_REQ{decrypt_valid_out}};
      rsp_data_q  <= (tag_out.valid && decrypt_valid_out) ? decrypted_data : '0;
      if (missing || spurious) lat_err_q <= 1'b1;
      if (ign_q != '0) ign_q <= ign_q - 1'b1;
      case (state_q)
        ARB_IDLE: begin
          if (grant_any) state_q <= ARB_ACTIVE;
        end
        ARB_ACTIVE: begin
          if (!grant_any) state_q <= (out_sum == '0) ? ARB_IDLE : ARB_DRAIN;
        end
        ARB_DRAIN: begin
          if (grant_any) state_q <= ARB_ACTIVE;
          else if (out_sum == '0) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign lat_err   = lat_err_q;

`ifdef ENCRYPT_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] grant_cnt_q;
  logic [15:0]            resp_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
      resp_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i]) grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
      end
      if (|rsp_valid_q) resp_cnt_q <= resp_cnt_q + 16'd1;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign resp_cnt  = resp_cnt_q;
`endif

endmodule

// File: tb/tb_encrypt_decrypt_arbiter.sv
// Bench for encrypt_decrypt_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_encrypt_decrypt_arbiter;
  import encrypt_config::*;

  localparam int LAT = 3;
  localparam int MO  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready;
  logic        enable;
  logic [7:0]  data_in_encrypt;
  logic        decrypt_valid_out = 1'b0;
  logic [7:0]  decrypted_data = '0;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        lat_err;
`ifdef ENCRYPT_ARB_STATS_EN
  logic [31:0] grant_cnt;
  logic [15:0] resp_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit rand_faults = 0;
  bit drop_req = 0;
  bit spur_req = 0;

  logic [7:0] dp_dat[int];

  // Reference model state
  int         m_credit[2];
  int         m_rr = 0;
  bit [1:0]   m_rv = '0;
  logic [7:0] m_rd = '0;
  bit         m_lat = 0;
  int         m_state = 0;
  int         last_rst = -100;
  int         m_grant = 0;
  int         m_resp = 0;
  int         ret_id[int];
  logic [7:0] ret_dat[int];

  encrypt_decrypt_arbiter #(
    .N_REQ   (2),
    .DATA_W  (8),
    .PIPE_LAT(LAT),
    .MAX_OUT (MO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .enable           (enable),
    .data_in_encrypt  (data_in_encrypt),
    .decrypt_valid_out(decrypt_valid_out),
    .decrypted_data   (decrypted_data),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
`ifdef ENCRYPT_ARB_STATS_EN
    .grant_cnt        (grant_cnt),
    .resp_cnt         (resp_cnt),
`endif
    .lat_err          (lat_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Datapath stand-in: echoes each enabled byte LAT cycles later, with optional faults.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    decrypt_valid_out = 1'b0;
    decrypted_data    = '0;
    if (dp_dat.exists(cyc)) begin
      if (drop_req || (rand_faults && $urandom_range(0, 39) == 0)) begin
        drop_req = 0;
      end else begin
        decrypt_valid_out = 1'b1;
        decrypted_data    = dp_dat[cyc];
      end
      dp_dat.delete(cyc);
    end else if (spur_req || (rand_faults && $urandom_range(0, 59) == 0)) begin
      spur_req          = 0;
      decrypt_valid_out = 1'b1;
      decrypted_data    = 8'($urandom);
    end
  end

  // Compare process: checks every cycle, then advances the model.
  initial forever begin
    int         eg;
    int         idx;
    int         id;
    int         sum;
    logic [1:0] er;
    logic [7:0] ed;
    bit [1:0]   nrv;
    logic [7:0] nrd;
    @(negedge clk);
    eg = -1;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        idx = (m_rr + k) % 2;
        if (eg < 0 && req_valid[idx] && m_credit[idx] < MO) eg = idx;
      end
    end
    er = (eg < 0) ? 2'b00 : 2'(1 << eg);
    ed = (eg < 0) ? 8'h00 : req_data[eg*8 +: 8];

    if (chk_en) begin
      chk("ready", req_ready, er);
      chk("enable", enable, er != 2'b00);
      chk("data_in", data_in_encrypt, ed);
      chk("rsp_valid", rsp_valid, m_rv);
      if (m_rv != 2'b00) chk("rsp_data", rsp_data, m_rd);
      chk("lat_err", lat_err, m_lat);
      chk("state", int'(dut.state_q), m_state);
    end

    if (enable === 1'b1) dp_dat[cyc + LAT] = data_in_encrypt;

    if (rst) begin
      m_credit[0] = 0;
      m_credit[1] = 0;
      m_rr = 0;
      m_rv = '0;
      m_rd = '0;
      m_lat = 0;
      m_state = int'(ARB_IDLE);
      m_grant = 0;
      m_resp = 0;
      ret_id.delete();
      ret_dat.delete();
      last_rst = cyc;
    end else begin
      nrv = '0;
      nrd = '0;
      if (ret_id.exists(cyc)) begin
        id = ret_id[cyc];
        if (m_credit[id] > 0) m_credit[id]--;
        if (decrypt_valid_out) begin
          nrv = 2'(1 << id);
          nrd = ret_dat[cyc];
          m_resp++;
        end else begin
          m_lat = 1;
        end
        ret_id.delete(cyc);
        ret_dat.delete(cyc);
      end else if (decrypt_valid_out && cyc > last_rst + LAT) begin
        m_lat = 1;
      end
      if (eg >= 0) begin
        m_credit[eg]++;
        ret_id[cyc + LAT] = eg;
        ret_dat[cyc + LAT] = ed;
        m_rr = (eg + 1) % 2;
        m_grant++;
      end
      m_rv = nrv;
      m_rd = nrd;
      sum = m_credit[0] + m_credit[1];
      if (eg >= 0) m_state = int'(ARB_ACTIVE);
      else if (sum > 0) m_state = int'(ARB_DRAIN);
      else m_state = int'(ARB_IDLE);
    end
  end

  initial begin
    logic [9:0] pat;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1;

    // Single requester, one byte
    req_valid = 2'b01;
    req_data = 16'h003C;
    @(negedge clk);
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_enable", enable, 1'b1);
    chk("t1_data", data_in_encrypt, 8'h3C);
    tick();
    req_valid = 2'b00;
    repeat (2) tick();
    @(negedge clk);
    chk("t1_rsp_early", rsp_valid, 2'b00);
    tick();
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_data", rsp_data, 8'h3C);
    chk("t1_lat_err", lat_err, 1'b0);
    repeat (3) tick();

    // One byte from requester 1 moves the pointer back to 0
    req_valid = 2'b10;
    req_data = 16'hC300;
    @(negedge clk);
    chk("t1b_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    repeat (5) tick();

    // Contention
    req_valid = 2'b11;
    req_data = 16'h5AA5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_rsp", rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("t2_rdata", rsp_data, (k % 2 == 0) ? 8'hA5 : 8'h5A);
      tick();
    end
    repeat (3) tick();

    // Credit limit
    pat = 10'b1100110011;
    req_valid = 2'b01;
    for (int k = 0; k < 10; k++) begin
      req_data[7:0] = 8'(8'h40 + k);
      @(negedge clk);
      chk("t3_grant", req_ready[0], pat[k]);
      tick();
    end
    req_valid = 2'b00;
    repeat (5) tick();

    // Missing datapath valid
    drop_req = 1;
    req_valid = 2'b01;
    req_data[7:0] = 8'h11;
    tick();
    req_valid = 2'b00;
    repeat (3) tick();
    @(negedge clk);
    chk("t4_no_rsp", rsp_valid, 2'b00);
    chk("t4_lat_err", lat_err, 1'b1);
    tick();
    req_valid = 2'b01;
    @(negedge clk);
    chk("t4_credit_a", req_ready, 2'b01);
    tick();
    @(negedge clk);
    chk("t4_credit_b", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    repeat (6) tick();
    @(negedge clk);
    chk("t4_sticky", lat_err, 1'b1);
    tick();

    // Reset with three bytes in flight
    req_valid = 2'b11;
    req_data = 16'h2233;
    repeat (3) tick();
    req_valid = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ready", req_ready, 2'b00);
    chk("t5_enable", enable, 1'b0);
    chk("t5_data", data_in_encrypt, 8'h00);
    chk("t5_rsp_valid", rsp_valid, 2'b00);
    chk("t5_rsp_data", rsp_data, 8'h00);
    chk("t5_lat_err", lat_err, 1'b0);
    tick();
    req_valid = 2'b10;
    req_data = 16'h7700;
    @(negedge clk);
    chk("t5_ready77", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    repeat (3) tick();
    @(negedge clk);
    chk("t5_rsp77", rsp_valid, 2'b10);
    chk("t5_rdata77", rsp_data, 8'h77);
    chk("t5_lat_ok", lat_err, 1'b0);
    repeat (3) tick();

    // Datapath valid with nothing in flight
    spur_req = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("t6_spur", lat_err, 1'b1);
    tick();

    // Random traffic with occasional faults and resets
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rand_faults = 1;
    for (int n = 0; n < 400; n++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_data = 16'($urandom);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    req_valid = 2'b00;
    rand_faults = 0;
    repeat (8) tick();
    @(negedge clk);
    chk("end_idle", int'(dut.state_q), int'(ARB_IDLE));
`ifdef ENCRYPT_ARB_STATS_EN
    chk("stat_grant", 32'(grant_cnt[15:0]) + 32'(grant_cnt[31:16]), m_grant);
    chk("stat_resp", 32'(resp_cnt), m_resp);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
